// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a sequencer master (software or an upper FSM) and the
// counter_sequencer block.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_dir;
  logic             cfg_reload;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, hold, abort, cfg_limit, cfg_dir, cfg_reload,
    input  Q, busy, tc, done, state
  );

  modport slave (
    input  start, hold, abort, cfg_limit, cfg_dir, cfg_reload,
    output Q, busy, tc, done, state
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run/stop controller around a WIDTH-bit counter: latches limit/direction/reload on start,
// then sequences RUN, PAUSE, terminal count and a one-cycle DONE phase.
module counter_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  counter_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Zero = '0;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  // Set when PAUSE was entered from a counted RUN cycle, so resuming advances the count.
  // Cleared when PAUSE was entered via reload, so the reloaded start value still gets a
  // RUN cycle of its own.
  logic             adv_q, adv_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] step_val;
  logic             at_term;

  always_comb begin
    start_val = dir_q ? limit_q : Zero;
    term_val  = dir_q ? Zero : limit_q;
    step_val  = dir_q ? (q_q - One) : (q_q + One);
    at_term   = (q_q == term_val);
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    limit_d  = limit_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    adv_d    = adv_q;

    if (bus.abort) begin
      state_d = StIdle;
      q_d     = Zero;
      adv_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            limit_d  = bus.cfg_limit;
            dir_d    = bus.cfg_dir;
            reload_d = bus.cfg_reload;
            q_d      = bus.cfg_dir ? bus.cfg_limit : Zero;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (at_term) begin
            // Terminal action takes precedence over hold.
            if (reload_q) begin
              q_d = start_val;
              if (bus.hold) begin
                state_d = StPause;
                adv_d   = 1'b0;
              end
            end else begin
              state_d = StDone;
            end
          end else if (bus.hold) begin
            state_d = StPause;
            adv_d   = 1'b1;
          end else begin
            q_d = step_val;
          end
        end
        StPause: begin
          if (!bus.hold) begin
            state_d = StRun;
            if (adv_q && !at_term) begin
              q_d = step_val;
            end
            adv_d = 1'b0;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      q_q      <= Zero;
      limit_q  <= Zero;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      adv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      limit_q  <= limit_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      adv_q    <= adv_d;
    end
  end

  // Status is decoded purely from registers, so it follows reset without a clock edge.
  always_comb begin
    bus.Q     = q_q;
    bus.state = state_q;
    bus.busy  = (state_q == StRun) || (state_q == StPause);
    bus.tc    = (state_q == StRun) && at_term;
    bus.done  = (state_q == StDone);
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer: reset, one-shot, periodic, hold,
// limit=0, ignored start/cfg, abort and asynchronous reset scenarios.
module tb_counter_sequencer;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   run_cycles;

  counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every status output at once.
  task automatic expect_all(input string tag, input logic [1:0] st, input logic [7:0] q,
                            input logic b, input logic t, input logic d);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".Q"},     32'(bus.Q),     32'(q));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".tc"},    32'(bus.tc),    32'(t));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] lim, input logic dir, input logic rel);
    bus.cfg_limit  = lim;
    bus.cfg_dir    = dir;
    bus.cfg_reload = rel;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.hold = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_limit = '0;
    bus.cfg_dir = 1'b0;
    bus.cfg_reload = 1'b0;
    step();
    step();
    expect_all("reset", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_all("idle_after_reset", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // One-shot up, limit=5
    do_start(8'd5, 1'b0, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      expect_all($sformatf("oneshot_q%0d", i), 2'd1, 8'(i), 1'b1, (i == 5), 1'b0);
      if (i < 5) step();
    end
    step();
    expect_all("oneshot_done", 2'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    step();
    expect_all("oneshot_idle", 2'd0, 8'd5, 1'b0, 1'b0, 1'b0);

    // Periodic down, limit=3: 3,2,1,0,3,2,1,0
    do_start(8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      expect_all($sformatf("periodic_%0d", i), 2'd1, 8'(3 - (i % 4)), 1'b1, ((i % 4) == 3),
                 1'b0);
      step();
    end
    expect_all("periodic_wrap2", 2'd1, 8'd3, 1'b1, 1'b0, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    expect_all("periodic_abort", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Hold at Q=4 during a one-shot up run, limit=10
    run_cycles = 0;
    do_start(8'd10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (bus.state == 2'd1) run_cycles++;
      step();
    end
    if (bus.state == 2'd1) run_cycles++;
    expect_all("hold_pre", 2'd1, 8'd4, 1'b1, 1'b0, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_all($sformatf("hold_pause%0d", i), 2'd2, 8'd4, 1'b1, 1'b0, 1'b0);
    end
    bus.hold = 1'b0;
    step();
    expect_all("hold_resume", 2'd1, 8'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (bus.state == 2'd1) run_cycles++;
      if (i < 5) step();
    end
    expect_all("hold_term", 2'd1, 8'd10, 1'b1, 1'b1, 1'b0);
    chk("hold_run_cycles", 32'(run_cycles), 32'd11);
    step();
    expect_all("hold_done", 2'd3, 8'd10, 1'b0, 1'b0, 1'b1);
    step();

    // limit=0 one-shot
    do_start(8'd0, 1'b0, 1'b0);
    expect_all("lim0_run", 2'd1, 8'd0, 1'b1, 1'b1, 1'b0);
    step();
    expect_all("lim0_done", 2'd3, 8'd0, 1'b0, 1'b0, 1'b1);
    step();
    expect_all("lim0_idle", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Start and cfg change during RUN are ignored; start during DONE is ignored
    do_start(8'd3, 1'b0, 1'b0);
    bus.cfg_limit = 8'd9;
    bus.cfg_dir = 1'b1;
    bus.cfg_reload = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect_all("ign_start_run", 2'd1, 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    expect_all("ign_term", 2'd1, 8'd3, 1'b1, 1'b1, 1'b0);
    step();
    expect_all("ign_done", 2'd3, 8'd3, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    expect_all("ign_start_done", 2'd0, 8'd3, 1'b0, 1'b0, 1'b0);

    // Abort at Q=7
    do_start(8'd20, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    expect_all("abort_pre", 2'd1, 8'd7, 1'b1, 1'b0, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    expect_all("abort_run", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Abort and start together in IDLE
    bus.cfg_limit = 8'd4;
    bus.cfg_dir = 1'b1;
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    expect_all("abort_start", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at Q=3
    do_start(8'd9, 1'b0, 1'b0);
    step();
    step();
    step();
    expect_all("arst_pre", 2'd1, 8'd3, 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    expect_all("arst_now", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    step();
    expect_all("arst_after", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
